// File: rtl/progress_tracker.sv
// progress_tracker: counts per-byte strobes against a latched size to drive a progress overlay
//   in : clk, reset_n (async, active-low), start (+size), byte_stb, stop
//   out: current, max, enable (RUN|HOLD), busy (RUN), complete (HOLD-entry pulse), stalled
module progress_tracker #(
  parameter logic [23:0] HOLD_CYCLES  = 24'd4000000,
  parameter logic [24:0] MIN_MAX      = 25'd128,
  parameter logic [23:0] STALL_CYCLES = 24'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [24:0] size,
  input  logic        byte_stb,
  input  logic        stop,
  output logic [24:0] current,
  output logic [24:0] max,
  output logic        enable,
  output logic        busy,
  output logic        complete,
  output logic        stalled
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t      state_q, state_d;
  logic [24:0] cur_q, cur_d, max_q, max_d, cur_inc;
  logic [23:0] stall_q, stall_d, hold_q, hold_d;
  logic        en_q, en_d, busy_q, busy_d, cmp_q, cmp_d, stl_q, stl_d, wd_fire;
  always_comb begin
    cur_inc = (byte_stb && cur_q < max_q) ? cur_q + 25'd1 : cur_q;
    // watchdog wins over a same-cycle byte_stb, so it looks only at the registered timer
    wd_fire = (STALL_CYCLES != '0) && (stall_q == STALL_CYCLES);
    state_d = state_q;
    cur_d   = cur_q;
    max_d   = max_q;
    en_d    = en_q;
    busy_d  = busy_q;
    cmp_d   = 1'b0;
    stl_d   = stl_q;
    stall_d = stall_q;
    hold_d  = hold_q;
    if (start) begin
      state_d = RUN;
      cur_d   = '0;
      max_d   = (size < MIN_MAX) ? MIN_MAX : size;
      en_d    = 1'b1;
      busy_d  = 1'b1;
      stl_d   = 1'b0;
      stall_d = '0;
    end else if (state_q == RUN) begin
      if (stop) begin
        state_d = HOLD;
        cur_d   = cur_inc;
        cmp_d   = (cur_inc == max_q);
        busy_d  = 1'b0;
        hold_d  = HOLD_CYCLES;
      end else if (wd_fire) begin
        state_d = HOLD;
        stl_d   = 1'b1;
        busy_d  = 1'b0;
        hold_d  = HOLD_CYCLES;
      end else begin
        cur_d   = cur_inc;
        stall_d = (byte_stb || STALL_CYCLES == '0) ? '0 : stall_q + 24'd1;
      end
    end else if (state_q == HOLD) begin
      state_d = (hold_q == '0) ? IDLE : HOLD;
      cur_d   = (hold_q == '0) ? '0 : cur_q;
      en_d    = (hold_q != '0);
      hold_d  = (hold_q == '0) ? hold_q : hold_q - 24'd1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      max_q   <= MIN_MAX;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      cmp_q   <= 1'b0;
      stl_q   <= 1'b0;
      stall_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      max_q   <= max_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      cmp_q   <= cmp_d;
      stl_q   <= stl_d;
      stall_q <= stall_d;
      hold_q  <= hold_d;
    end
  end
  assign current  = cur_q;
  assign max      = max_q;
  assign enable   = en_q;
  assign busy     = busy_q;
  assign complete = cmp_q;
  assign stalled  = stl_q;
endmodule

// File: tb/tb_progress_tracker.sv
// tb_progress_tracker: directed scenarios for progress_tracker (HOLD=10, STALL=20, MIN_MAX=128)
module tb_progress_tracker;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [24:0] size = '0;
  logic        byte_stb = 1'b0;
  logic        stop = 1'b0;
  logic [24:0] current, max;
  logic        enable, busy, complete, stalled;
  int          checks = 0;
  int          errors = 0;
  progress_tracker #(
    .HOLD_CYCLES(24'd10),
    .MIN_MAX(25'd128),
    .STALL_CYCLES(24'd20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .size(size), .byte_stb(byte_stb),
    .stop(stop), .current(current), .max(max), .enable(enable), .busy(busy),
    .complete(complete), .stalled(stalled)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [24:0] s);
    start = 1'b1;
    size = s;
    tick();
    start = 1'b0;
  endtask
  task automatic strobes(input int n);
    byte_stb = 1'b1;
    repeat (n) tick();
    byte_stb = 1'b0;
  endtask
  task automatic do_stop;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
  task automatic test_reset;
    #12;
    checks++; if (current !== 25'd0) begin errors++; $display("FAIL reset_current got %0d exp 0", current); end
    checks++; if (max !== 25'd128) begin errors++; $display("FAIL reset_max got %0d exp 128", max); end
    checks++; if ({enable, busy, complete, stalled} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {enable, busy, complete, stalled}); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic test_normal;
    int cmp_cnt;
    int en_low;
    do_start(25'd200);
    checks++; if ({enable, busy} !== 2'b11) begin errors++; $display("FAIL start_en_busy got %b exp 11", {enable, busy}); end
    checks++; if (max !== 25'd200) begin errors++; $display("FAIL start_max got %0d exp 200", max); end
    strobes(200);
    checks++; if (current !== 25'd200) begin errors++; $display("FAIL count200 got %0d exp 200", current); end
    do_stop();
    checks++; if ({enable, busy, complete} !== 3'b101) begin errors++; $display("FAIL hold_entry got %b exp 101", {enable, busy, complete}); end
    cmp_cnt = 1;
    en_low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (complete) cmp_cnt++;
      if (!enable) en_low++;
    end
    checks++; if (cmp_cnt !== 1) begin errors++; $display("FAIL complete_pulses got %0d exp 1", cmp_cnt); end
    checks++; if (en_low !== 0) begin errors++; $display("FAIL hold_enable_low_cycles got %0d exp 0", en_low); end
    checks++; if (current !== 25'd200) begin errors++; $display("FAIL hold_current got %0d exp 200", current); end
    tick();
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL idle_enable got %b exp 0", enable); end
    checks++; if (current !== 25'd0) begin errors++; $display("FAIL idle_current got %0d exp 0", current); end
  endtask
  task automatic test_saturate;
    do_start(25'd5);
    checks++; if (max !== 25'd128) begin errors++; $display("FAIL min_max got %0d exp 128", max); end
    strobes(300);
    checks++; if (current !== 25'd128) begin errors++; $display("FAIL saturate got %0d exp 128", current); end
    do_stop();
    checks++; if (complete !== 1'b1) begin errors++; $display("FAIL sat_complete got %b exp 1", complete); end
    repeat (11) tick();
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL sat_idle_enable got %b exp 0", enable); end
  endtask
  task automatic test_stall;
    do_start(25'd1000);
    strobes(3);
    repeat (21) tick();
    checks++; if ({enable, busy, stalled, complete} !== 4'b1010) begin errors++; $display("FAIL stall_flags got %b exp 1010", {enable, busy, stalled, complete}); end
    checks++; if (current !== 25'd3) begin errors++; $display("FAIL stall_current got %0d exp 3", current); end
    do_start(25'd300);
    checks++; if ({busy, stalled} !== 2'b10) begin errors++; $display("FAIL stall_clear got %b exp 10", {busy, stalled}); end
  endtask
  task automatic test_same_cycle;
    strobes(50);
    checks++; if (current !== 25'd50) begin errors++; $display("FAIL pre50 got %0d exp 50", current); end
    start = 1'b1;
    byte_stb = 1'b1;
    size = 25'd400;
    tick();
    start = 1'b0;
    byte_stb = 1'b0;
    checks++; if (current !== 25'd0) begin errors++; $display("FAIL start_stb_current got %0d exp 0", current); end
    checks++; if (max !== 25'd400) begin errors++; $display("FAIL start_stb_max got %0d exp 400", max); end
    strobes(50);
    stop = 1'b1;
    byte_stb = 1'b1;
    tick();
    stop = 1'b0;
    byte_stb = 1'b0;
    checks++; if (current !== 25'd51) begin errors++; $display("FAIL stop_stb_current got %0d exp 51", current); end
    checks++; if ({enable, busy, complete} !== 3'b100) begin errors++; $display("FAIL stop_stb_flags got %b exp 100", {enable, busy, complete}); end
  endtask
  task automatic test_hold_restart;
    repeat (2) tick();
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL hold_pre_enable got %b exp 1", enable); end
    do_start(25'd10);
    checks++; if ({enable, busy} !== 2'b11) begin errors++; $display("FAIL restart_flags got %b exp 11", {enable, busy}); end
    checks++; if (current !== 25'd0) begin errors++; $display("FAIL restart_current got %0d exp 0", current); end
    checks++; if (max !== 25'd128) begin errors++; $display("FAIL restart_max got %0d exp 128", max); end
  endtask
  task automatic test_mid_reset;
    strobes(77);
    checks++; if (current !== 25'd77) begin errors++; $display("FAIL pre77 got %0d exp 77", current); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({enable, busy} !== 2'b00) begin errors++; $display("FAIL async_flags got %b exp 00", {enable, busy}); end
    checks++; if (current !== 25'd0) begin errors++; $display("FAIL async_current got %0d exp 0", current); end
    checks++; if (max !== 25'd128) begin errors++; $display("FAIL async_max got %0d exp 128", max); end
    @(negedge clk);
    reset_n = 1'b1;
    strobes(5);
    do_stop();
    checks++; if (current !== 25'd0) begin errors++; $display("FAIL idle_stb_current got %0d exp 0", current); end
    checks++; if ({enable, busy, complete} !== 3'b000) begin errors++; $display("FAIL idle_stop_flags got %b exp 000", {enable, busy, complete}); end
  endtask
  initial begin
    test_reset();
    test_normal();
    test_saturate();
    test_stall();
    test_same_cycle();
    test_hold_restart();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
